// File: rtl/cache_hit_window_stats_if.sv
// cache_hit_window_stats_if: valid/ready channel carrying one window record (hits, length)
interface cache_hit_window_stats_if #(
    parameter int HW = 10
);
    logic          win_valid;
    logic          win_ready;
    logic [HW-1:0] win_hits;
    logic [HW-1:0] win_len;

    modport master(output win_valid, win_hits, win_len, input win_ready);
    modport slave(input win_valid, win_hits, win_len, output win_ready);
endinterface

// File: rtl/cache_hit_window_stats.sv
// cache_hit_window_stats: bins cache hit/miss results into fixed windows, queues per-window hit counts, keeps saturating totals
module cache_hit_window_stats #(
    parameter int WINDOW = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int TOT_W = 32,
    localparam int HW = $clog2(WINDOW + 1),
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   acc_valid,
    input  logic                   acc_hit,
    input  logic                   flush,
    cache_hit_window_stats_if.master win,
    output logic [LW-1:0]          fifo_level,
    output logic                   overflow,
    output logic [TOT_W-1:0]       tot_acc,
    output logic [TOT_W-1:0]       tot_hits
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [HW-1:0]   cnt_acc, cnt_hit, push_hits, push_len;
    logic [2*HW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic            close, push, pop, full, wr_en;

    // A record is produced by the closing access, or by a flush while anything (incl. this access) is pending
    always_comb begin
        close     = acc_valid && cnt_acc == HW'(WINDOW - 1);
        push      = close || (flush && (acc_valid || cnt_acc != '0));
        push_hits = cnt_hit + HW'(acc_valid & acc_hit);
        push_len  = cnt_acc + HW'(acc_valid);
        pop       = win.win_valid & win.win_ready;
        full      = fifo_level == LW'(FIFO_DEPTH);
        wr_en     = push && (!full || pop);
    end

    assign win.win_valid = fifo_level != '0;
    assign {win.win_hits, win.win_len} = win.win_valid ? mem[rd_ptr] : '0;

    // Window counters restart on every push, so a flush coinciding with a close yields one record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_acc <= '0;
            cnt_hit <= '0;
        end else begin
            cnt_acc <= push ? '0 : push_len;
            cnt_hit <= push ? '0 : push_hits;
        end
    end

    // Record storage; only written when the push is accepted
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {push_hits, push_len};
    end

    // Pointer/level bookkeeping; a push into a full FIFO without a pop is dropped and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + PW'(pop);
            wr_ptr     <= wr_ptr + PW'(wr_en);
            fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
            overflow   <= overflow | (push & full & ~pop);
        end
    end

    // Run totals stick at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_acc  <= '0;
            tot_hits <= '0;
        end else begin
            tot_acc  <= tot_acc + TOT_W'(acc_valid && !(&tot_acc));
            tot_hits <= tot_hits + TOT_W'(acc_valid && acc_hit && !(&tot_hits));
        end
    end
endmodule
